// File: rtl/sys_uart_tx_if.sv
// rtl/sys_uart_tx_if.sv - system bus read/write port bundle for sys_uart_tx
interface sys_uart_tx_if;
   logic [31:0] sys_w_addr;
   logic [31:0] sys_w_line;
   logic        sys_write;
   logic [31:0] sys_r_addr;
   logic        sys_read;
   logic [31:0] sys_r_line;
   logic        sys_r_hit;

   modport master (
      output sys_w_addr, sys_w_line, sys_write, sys_r_addr, sys_read,
      input  sys_r_line, sys_r_hit
   );

   modport slave (
      input  sys_w_addr, sys_w_line, sys_write, sys_r_addr, sys_read,
      output sys_r_line, sys_r_hit
   );
endinterface

// File: rtl/sys_uart_tx.sv
// rtl/sys_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module sys_uart_tx #(
   parameter logic [31:0] BASE      = 32'h0000_0100,
   parameter int          DEPTH     = 4,
   parameter logic [15:0] DIV_RESET = 16'd433
) (
   input  logic         clk,
   input  logic         rst,
   sys_uart_tx_if.slave bus,
   output logic         tx
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic          enable;
   logic [15:0]   div;
   logic [15:0]   period;
   logic [15:0]   bit_cnt;
   logic [7:0]    shift;
   logic [2:0]    bit_idx;

   logic [31:0]   w_off;
   logic [31:0]   r_off;
   logic          w_hit;
   logic          r_hit_c;
   logic          empty;
   logic          full;
   logic          bit_end;
   logic          pop;
   logic          push;
   logic          push_ok;
   logic          ovf_clr;
   logic [31:0]   rd_val;
   logic [4:0]    count_ext;
   logic          unused_bits;

   // Offsets wrap on subtraction, so one unsigned compare covers BASE..BASE+3.
   assign w_off     = bus.sys_w_addr - BASE;
   assign r_off     = bus.sys_r_addr - BASE;
   assign w_hit     = bus.sys_write && (w_off < 32'd4);
   assign r_hit_c   = bus.sys_read && (r_off < 32'd4);
   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign bit_end   = (bit_cnt == period);
   assign pop       = enable && !empty &&
                      ((state == S_IDLE) || ((state == S_STOP) && bit_end));
   assign push      = w_hit && (w_off[1:0] == 2'd0);
   assign push_ok   = push && (!full || pop);
   assign ovf_clr   = w_hit && (w_off[1:0] == 2'd3) && bus.sys_w_line[1];
   assign count_ext = 5'(count);
   assign unused_bits = ^bus.sys_w_line[31:16];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         enable <= 1'b0;
         div    <= DIV_RESET;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= bus.sys_w_line[7:0];
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)
            count <= count + 1'b1;
         else if (pop && !push_ok)
            count <= count - 1'b1;
         // A drop on the same edge as a clear still leaves ovf set.
         ovf <= (ovf && !ovf_clr) || (push && !push_ok);
         if (w_hit && (w_off[1:0] == 2'd2))
            div <= bus.sys_w_line[15:0];
         if (w_hit && (w_off[1:0] == 2'd3))
            enable <= bus.sys_w_line[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         tx      <= 1'b1;
         period  <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift   <= mem[rd_ptr];
                  period  <= div;
                  bit_cnt <= '0;
                  tx      <= 1'b0;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= S_DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  // Chain straight into the next start bit when data is waiting.
                  if (pop) begin
                     shift  <= mem[rd_ptr];
                     period <= div;
                     tx     <= 1'b0;
                     state  <= S_START;
                  end else begin
                     tx    <= 1'b1;
                     state <= S_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      case (r_off[1:0])
         2'd1:    rd_val = {23'd0, count_ext, ovf, (state != S_IDLE), full, empty};
         2'd2:    rd_val = {16'd0, div};
         2'd3:    rd_val = {31'd0, enable};
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.sys_r_hit  <= 1'b0;
         bus.sys_r_line <= '0;
      end else begin
         bus.sys_r_hit  <= r_hit_c;
         bus.sys_r_line <= r_hit_c ? rd_val : 32'd0;
      end
   end
endmodule
